// File: rtl/operand_gen_pkg.sv
// Shared types and constants for the operand pair generator.
package operand_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Galois (right-shifting) feedback masks for maximal-length sequences.
  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  localparam int CHK_FIFO_DEPTH = 8;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      16:      return TAPS_16;
      32:      return TAPS_32;
      default: return TAPS_8;
    endcase
  endfunction

endpackage

// File: rtl/operand_gen_fifo.sv
// Small synchronous FIFO holding expected sums; head word is visible without a pop.
module operand_gen_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   used;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Depth is tiny, so the head is read combinationally for same-cycle compare.
  assign pop_data = mem[rd_ptr];
  assign empty    = (used == '0);
  assign full     = (used == (AW+1)'(DEPTH));

endmodule

// File: rtl/operand_gen.sv
// Operand pair transmitter feeding the adder's A/B valid/ready channels.
// Optional returned-sum checking is built when OPERAND_GEN_CHECK_EN is defined.
module operand_gen
  import operand_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic              busy,
  output logic              done,
`ifdef OPERAND_GEN_CHECK_EN
  input  logic [DATA_W:0]   sum_data,
  input  logic              sum_valid,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
`endif
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  state_t            state, state_next;
  logic              a_acc, b_acc;
  logic              mode_reg;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] pat_next;
  logic [DATA_W-1:0] b_pat;
  logic [CNT_W-1:0]  count_reg;
  logic              in_send, start_ok;
  logic              a_fire, b_fire, pair_done, last_pair;
  logic              gate_ok, fifo_idle;

  assign in_send  = (state == SEND);
  assign start_ok = (state == IDLE) && start;

  assign a_valid   = in_send && gate_ok && !a_acc;
  assign b_valid   = in_send && gate_ok && !b_acc;
  assign a_fire    = a_valid && a_ready;
  assign b_fire    = b_valid && b_ready;
  // A pair completes when each half is either already taken or taken now.
  assign pair_done = in_send && (a_acc || a_fire) && (b_acc || b_fire);
  assign last_pair = pair_done && ((sent_cnt + CNT_W'(1)) == count_reg);

  assign b_pat  = mode_reg ? {pat[DATA_W-2:0], pat[DATA_W-1]} : ~pat;
  assign a_data = in_send ? pat   : '0;
  assign b_data = in_send ? b_pat : '0;

  always_comb begin
    pat_next = pat + DATA_W'(1);
    if (mode_reg) pat_next = pat[0] ? ((pat >> 1) ^ TAPS) : (pat >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = (count == '0) ? DONE : SEND;
      SEND: begin
        busy = 1'b1;
        if (last_pair) state_next = DONE;
      end
      DONE: begin
        done = fifo_idle;
        busy = !fifo_idle;
        if (fifo_idle) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_acc     <= 1'b0;
      b_acc     <= 1'b0;
      mode_reg  <= 1'b0;
      pat       <= DATA_W'(1);
      count_reg <= '0;
      sent_cnt  <= '0;
    end else if (start_ok) begin
      a_acc     <= 1'b0;
      b_acc     <= 1'b0;
      mode_reg  <= mode;
      pat       <= (mode && seed == '0) ? DATA_W'(1) : seed;
      count_reg <= count;
      sent_cnt  <= '0;
    end else if (pair_done) begin
      a_acc    <= 1'b0;
      b_acc    <= 1'b0;
      pat      <= pat_next;
      sent_cnt <= sent_cnt + CNT_W'(1);
    end else begin
      if (a_fire) a_acc <= 1'b1;
      if (b_fire) b_acc <= 1'b1;
    end
  end

`ifdef OPERAND_GEN_CHECK_EN
  logic [DATA_W:0] exp_sum;
  logic            f_empty, f_full, f_pop;

  assign f_pop = sum_valid && !f_empty;

  operand_gen_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (CHK_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pair_done),
    .push_data ({1'b0, a_data} + {1'b0, b_data}),
    .pop       (f_pop),
    .pop_data  (exp_sum),
    .empty     (f_empty),
    .full      (f_full)
  );

  assign gate_ok   = !f_full;
  assign fifo_idle = f_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (start_ok) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (sum_valid && (f_empty || sum_data != exp_sum)) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign gate_ok   = 1'b1;
  assign fifo_idle = 1'b1;
`endif

endmodule

// File: tb/tb_operand_gen.sv
// Bench for operand_gen: table of runs checked cycle-by-cycle against a pair-level model.
`timescale 1ns/1ps
module tb_operand_gen;
  import operand_gen_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;
`ifdef OPERAND_GEN_CHECK_EN
  localparam int TAIL = 1;
`else
  localparam int TAIL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, mode, a_ready, b_ready;
  logic [CW-1:0] count;
  logic [DW-1:0] seed;
  logic [DW-1:0] a_data, b_data;
  logic          a_valid, b_valid, busy, done;
  logic [CW-1:0] sent_cnt;
`ifdef OPERAND_GEN_CHECK_EN
  logic [DW:0]   sum_data;
  logic          sum_valid, err;
  logic [CW-1:0] err_cnt;
  logic [DW:0]   sq[$];
`endif

  int vecs = 0;
  int errs = 0;
  logic [31:0]   tap_word;
  logic [DW-1:0] taps8;

  typedef struct {
    bit        m;
    logic [7:0] s;
    int        n;
    int        rmode;
    logic [7:0] a0, b0, al, bl;
  } vec_t;
  vec_t tbl[7];

  operand_gen #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .mode(mode), .seed(seed),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .busy(busy), .done(done),
`ifdef OPERAND_GEN_CHECK_EN
    .sum_data(sum_data), .sum_valid(sum_valid), .err(err), .err_cnt(err_cnt),
`endif
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pair k of a run, computed straight from the pattern rules.
  function automatic logic [7:0] ref_a(input bit m, input logic [7:0] s, input int k);
    logic [7:0] l;
    if (!m) return s + 8'(k);
    l = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ taps8) : (l >> 1);
    return l;
  endfunction

  function automatic logic [7:0] ref_b(input bit m, input logic [7:0] a);
    return m ? {a[6:0], a[7]} : ~a;
  endfunction

  task automatic run(input bit m, input logic [7:0] s, input int n, input int rmode,
                     output logic [7:0] a0, output logic [7:0] b0,
                     output logic [7:0] al, output logic [7:0] bl);
    int p = 0, tw = 0, cyc = 0;
    bit ag = 0, bg = 0, act, dexp, dexp_n;
    logic [7:0] ea, eb;
    a0 = '0; b0 = '0; al = '0; bl = '0;
    mode = m; seed = s; count = CW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    act = (n != 0);
    dexp = (n == 0);
    while ((act || tw > 0 || dexp) && cyc < 300) begin
      ea = ref_a(m, s, p);
      eb = ref_b(m, ea);
      chk("busy", 32'(busy), 32'(act || tw > 0));
      chk("done", 32'(done), 32'(dexp));
      chk("sent_cnt", 32'(sent_cnt), 32'(p));
      chk("a_valid", 32'(a_valid), 32'(act && !ag));
      chk("b_valid", 32'(b_valid), 32'(act && !bg));
      if (act && !ag) chk("a_data", 32'(a_data), 32'(ea));
      if (act && !bg) chk("b_data", 32'(b_data), 32'(eb));
      dexp_n = 1'b0;
      if (tw > 0) begin
        tw--;
        if (tw == 0) dexp_n = 1'b1;
      end
      case (rmode)
        1:       begin a_ready = 1'($urandom_range(0, 1)); b_ready = 1'($urandom_range(0, 1)); end
        2:       begin a_ready = 1'b1; b_ready = (cyc >= 5); end
        default: begin a_ready = 1'b1; b_ready = 1'b1; end
      endcase
      // A stray start with different parameters must not disturb the run.
      start = act && (cyc == 2);
      if (start) begin count = 16'd7; seed = 8'h55; mode = ~m; end
`ifdef OPERAND_GEN_CHECK_EN
      sum_valid = (sq.size() != 0);
      sum_data  = sum_valid ? sq.pop_front() : '0;
`endif
      if (act) begin
        if (!ag && a_ready) begin
          ag = 1'b1;
          if (p == 0)     a0 = a_data;
          if (p == n - 1) al = a_data;
        end
        if (!bg && b_ready) begin
          bg = 1'b1;
          if (p == 0)     b0 = b_data;
          if (p == n - 1) bl = b_data;
        end
        if (ag && bg) begin
`ifdef OPERAND_GEN_CHECK_EN
          sq.push_back({1'b0, ea} + {1'b0, eb});
`endif
          p++; ag = 1'b0; bg = 1'b0;
          if (p == n) begin
            act = 1'b0;
            if (TAIL == 0) dexp_n = 1'b1;
            else           tw = TAIL;
          end
        end
      end
      dexp = dexp_n;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
`ifdef OPERAND_GEN_CHECK_EN
    sum_valid = 1'b0;
    chk("err_clean", 32'(err), 32'd0);
`endif
    chk("run_timeout", 32'(act || tw > 0 || dexp), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_cnt", 32'(sent_cnt), 32'(n));
    chk("post_valid", 32'(a_valid | b_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] a0, b0, al, bl;
    rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; count = '0;
    a_ready = 1'b0; b_ready = 1'b0;
`ifdef OPERAND_GEN_CHECK_EN
    sum_valid = 1'b0; sum_data = '0;
`endif
    tap_word = lfsr_taps(DW);
    taps8 = tap_word[7:0];
    tbl[0] = '{1'b0, 8'hFE, 3, 0, 8'hFE, 8'h01, 8'h00, 8'hFF};
    tbl[1] = '{1'b0, 8'hFE, 3, 2, 8'hFE, 8'h01, 8'h00, 8'hFF};
    tbl[2] = '{1'b0, 8'h10, 5, 1, 8'h10, 8'hEF, 8'h14, 8'hEB};
    tbl[3] = '{1'b1, 8'h00, 2, 0, 8'h01, 8'h02, 8'hB8, 8'h71};
    tbl[4] = '{1'b1, 8'h01, 3, 1, 8'h01, 8'h02, 8'h5C, 8'hB8};
    tbl[5] = '{1'b0, 8'h7F, 1, 1, 8'h7F, 8'h80, 8'h7F, 8'h80};
    tbl[6] = '{1'b0, 8'h33, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'({a_valid, b_valid}), 32'd0);
    chk("rst_flags", 32'({busy, done}), 32'd0);
    chk("rst_cnt", 32'(sent_cnt), 32'd0);
    chk("rst_data", 32'({a_data, b_data}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].m, tbl[i].s, tbl[i].n, tbl[i].rmode, a0, b0, al, bl);
      if (tbl[i].n != 0) begin
        chk($sformatf("v%0d_a_first", i), 32'(a0), 32'(tbl[i].a0));
        chk($sformatf("v%0d_b_first", i), 32'(b0), 32'(tbl[i].b0));
        chk($sformatf("v%0d_a_last", i), 32'(al), 32'(tbl[i].al));
        chk($sformatf("v%0d_b_last", i), 32'(bl), 32'(tbl[i].bl));
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of a stalled run.
    mode = 1'b0; seed = 8'h20; count = 16'd10; start = 1'b1;
    a_ready = 1'b0; b_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_valid_pre", 32'(a_valid & b_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_valid_drop", 32'({a_valid, b_valid}), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("mid_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_done2", 32'(done), 32'd0);
    run(1'b0, 8'h20, 2, 0, a0, b0, al, bl);
    chk("restart_a", 32'(a0), 32'h20);
    chk("restart_b", 32'(b0), 32'hDF);
    @(posedge clk); #1;

`ifdef OPERAND_GEN_CHECK_EN
    mode = 1'b0; seed = 8'h30; count = 16'd3; start = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) chk("chk_err_ok", 32'(err), 32'd0);
      sum_valid = (c >= 1 && c <= 3);
      sum_data  = (c == 2) ? 9'h0FE : 9'h0FF;
      @(posedge clk); #1;
    end
    sum_valid = 1'b0;
    chk("chk_err_set", 32'(err), 32'd1);
    chk("chk_err_cnt1", 32'(err_cnt), 32'd1);
    sum_valid = 1'b1; sum_data = 9'h0FF;
    @(posedge clk); #1;
    sum_valid = 1'b0;
    chk("chk_err_cnt2", 32'(err_cnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
